nyakuo_decode: RTL
==================

NYAKUO_DECODE -- requirements
Module: nyakuo_decode

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width for pc and immediate; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 2, meaning decoded-entry buffer depth; legal values are powers of two from 2 to 16.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 flush  in  1  discard all buffered entries and the current input.
REQ-006 in_valid  in  1  fetch word present.
REQ-007 in_ready  out  1  decoder can accept a word.
REQ-008 in_instr  in  32  raw RV32 instruction word.
REQ-009 in_pc  in  XLEN  pc of in_instr.
REQ-010 out_valid  out  1  decoded entry at buffer head.
REQ-011 out_ready  in  1  consumer accepts the head entry.
REQ-012 out_op  out  instruction enum width  decoded opcode.
REQ-013 out_rd, out_rs1, out_rs2  out  5 each  register indices, forced to 0 when unused by out_op.
REQ-014 out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J format per op), 0 for R-type.
REQ-015 out_pc  out  XLEN  pc carried with the entry.
REQ-016 out_illegal  out  1  word is not a supported instruction.

Function
REQ-017 Transfer in = in_valid&&in_ready; transfer out = out_valid&&out_ready.
REQ-018 in_ready shall be (count<DEPTH), with no combinational path from out_ready.
REQ-019 Accepted word shall be decoded combinationally and written into the buffer; out_valid rises the cycle after acceptance (latency 1) when the buffer was empty.
REQ-020 Ordering strictly FIFO; count increments on transfer-in, decrements on transfer-out, unchanged when both occur.
REQ-021 Full (count==DEPTH): in_ready=0; a simultaneous pop does not let a push in that cycle.
REQ-022 Empty: out_valid=0; out_* payload holds its last value and is don't-care.
REQ-023 Read/write pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
REQ-024 flush asserted: next cycle count=0, out_valid=0; any same-cycle push and pop are discarded; flush wins over all.
REQ-025 Supported base ops: the full RV32I list in the shared enum (shift, arithmetic, logic, compare, branch, jump, load, store, FENCE, FENCE_I, ECALL, EBREAK).
REQ-026 Any unsupported opcode/funct3/funct7 combination, and in_instr[1:0]!=2'b11, shall produce out_illegal=1, out_op=ADDI, rd/rs1/rs2=0, imm=0.
REQ-027 Immediates shall sign-extend from bit 31 of in_instr to XLEN; U-type places imm[31:12] and zeroes [11:0] before extension.

Reset
REQ-028 On rst: count=0, pointers=0, out_valid=0, in_ready=1 (after reset), out_illegal=0; buffer contents unspecified.
REQ-029 Reset asserted mid-transfer aborts it; no entry survives reset.

Configuration
REQ-030 Macro NYAKUO_ZICSR_EN defined: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI decode legally, csr address (in_instr[31:20]) zero-extended into out_imm, uimm carried in out_rs1.
REQ-031 Macro undefined: opcode 7'h73 with funct3!=0 shall flag out_illegal=1; buffer behaviour otherwise identical.

Structure
REQ-032 Package nyakuo_pkg holds the instruction enum (multi-bit logic type sized to its member count, no duplicate members), RV32 opcode constants, and a packed decoded-entry struct.
REQ-033 Buffer is sub-module nyakuo_fifo, parametrised by entry width and DEPTH; decode logic stays in nyakuo_decode.

Verification
REQ-034 Push 0x00500093 at pc 0x100, out_ready=1 -> next cycle out_op=ADDI, rd=1, rs1=0, imm=5, pc=0x100, illegal=0.
REQ-035 Push 0xFFF00113 -> out_op=ADDI, rd=2, imm=0xFFFFFFFF (XLEN=32) / 0xFFFFFFFFFFFFFFFF (XLEN=64).
REQ-036 out_ready=0, push DEPTH words -> in_ready=0 after the DEPTH-th; then pop all -> exact input order, pointers wrap.
REQ-037 Buffer holds 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, pushed word lost.
REQ-038 Push 0x30001073 -> with NYAKUO_ZICSR_EN out_op=CSRRW, imm=0x300, illegal=0; without it illegal=1.
REQ-039 Push 0x00000000, then assert rst asynchronously mid-cycle -> illegal=1 entry seen, then out_valid=0 immediately on rst.

Source files
------------

// File: rtl/nyakuo_pkg.sv
// Shared decode types for the nyakuo front end: instruction enum, RV32 opcodes, decoded-entry struct.
// The CSR members are always present so downstream logic sees one enum regardless of NYAKUO_ZICSR_EN.
package nyakuo_pkg;

   typedef enum logic [5:0] {
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
      OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK,
      OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
   } op_e;

   localparam logic [6:0] OPC_LUI     = 7'h37;
   localparam logic [6:0] OPC_AUIPC   = 7'h17;
   localparam logic [6:0] OPC_JAL     = 7'h6F;
   localparam logic [6:0] OPC_JALR    = 7'h67;
   localparam logic [6:0] OPC_BRANCH  = 7'h63;
   localparam logic [6:0] OPC_LOAD    = 7'h03;
   localparam logic [6:0] OPC_STORE   = 7'h23;
   localparam logic [6:0] OPC_OPIMM   = 7'h13;
   localparam logic [6:0] OPC_OP      = 7'h33;
   localparam logic [6:0] OPC_MISCMEM = 7'h0F;
   localparam logic [6:0] OPC_SYSTEM  = 7'h73;

   // Width-independent part of an entry; imm and pc (XLEN wide) travel beside it in the buffer.
   typedef struct packed {
      op_e        op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       illegal;
   } dec_t;

   localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/nyakuo_fifo.sv
// Decoded-entry buffer: DEPTH-entry FIFO with naturally wrapping pointers and a synchronous flush.
// Callers gate push/pop with full/empty; storage is cleared on reset so the head reads as zero.
module nyakuo_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_flush,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic [WIDTH-1:0]        i_wdata,
   output logic [WIDTH-1:0]        o_rdata,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [PW:0]      r_count;
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_wdata;
            r_wrPtr        <= r_wrPtr + PW'(1);
         end
         if (i_pop) r_rdPtr <= r_rdPtr + PW'(1);
         if (i_push && !i_pop)      r_count <= r_count + (PW+1)'(1);
         else if (!i_push && i_pop) r_count <= r_count - (PW+1)'(1);
      end
   end

   assign o_rdata = r_mem[r_rdPtr];
   assign o_count = r_count;

endmodule

// File: rtl/nyakuo_decode.sv
// RV32I decoder feeding a small FIFO of decoded entries (latency 1 into an empty buffer).
// Define NYAKUO_ZICSR_EN to decode the six Zicsr instructions; otherwise they are flagged illegal.
module nyakuo_decode
   import nyakuo_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output op_e             out_op,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_pc,
   output logic            out_illegal
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = DEC_W + 2 * XLEN;

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
   op_e         w_op;
   logic        w_legal, w_useRd, w_useRs1, w_useRs2;
   logic [31:0] w_imm32;
   dec_t        w_dec;
   logic [XLEN-1:0] w_imm;
   logic [CW-1:0]   w_count;
   logic [EW-1:0]   w_rdata;
   dec_t        w_head;
   logic        w_push, w_pop;

   assign w_opc  = in_instr[6:0];
   assign w_f3   = in_instr[14:12];
   assign w_f7   = in_instr[31:25];
   assign w_immI = {{20{in_instr[31]}}, in_instr[31:20]};
   assign w_immS = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign w_immB = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign w_immU = {in_instr[31:12], 12'b0};
   assign w_immJ = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   // Each branch claims legality up front and the default arms of inner cases revoke it.
   always_comb begin
      w_op     = OP_ADDI;
      w_legal  = 1'b0;
      w_useRd  = 1'b0;
      w_useRs1 = 1'b0;
      w_useRs2 = 1'b0;
      w_imm32  = '0;
      if (in_instr[1:0] == 2'b11) begin
         case (w_opc)
            OPC_LUI: begin
               w_op = OP_LUI; w_legal = 1'b1; w_useRd = 1'b1; w_imm32 = w_immU;
            end
            OPC_AUIPC: begin
               w_op = OP_AUIPC; w_legal = 1'b1; w_useRd = 1'b1; w_imm32 = w_immU;
            end
            OPC_JAL: begin
               w_op = OP_JAL; w_legal = 1'b1; w_useRd = 1'b1; w_imm32 = w_immJ;
            end
            OPC_JALR: begin
               w_op = OP_JALR; w_legal = (w_f3 == 3'b000);
               w_useRd = 1'b1; w_useRs1 = 1'b1; w_imm32 = w_immI;
            end
            OPC_BRANCH: begin
               w_legal = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1; w_imm32 = w_immB;
               case (w_f3)
                  3'b000:  w_op = OP_BEQ;
                  3'b001:  w_op = OP_BNE;
                  3'b100:  w_op = OP_BLT;
                  3'b101:  w_op = OP_BGE;
                  3'b110:  w_op = OP_BLTU;
                  3'b111:  w_op = OP_BGEU;
                  default: w_legal = 1'b0;
               endcase
            end
            OPC_LOAD: begin
               w_legal = 1'b1; w_useRd = 1'b1; w_useRs1 = 1'b1; w_imm32 = w_immI;
               case (w_f3)
                  3'b000:  w_op = OP_LB;
                  3'b001:  w_op = OP_LH;
                  3'b010:  w_op = OP_LW;
                  3'b100:  w_op = OP_LBU;
                  3'b101:  w_op = OP_LHU;
                  default: w_legal = 1'b0;
               endcase
            end
            OPC_STORE: begin
               w_legal = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1; w_imm32 = w_immS;
               case (w_f3)
                  3'b000:  w_op = OP_SB;
                  3'b001:  w_op = OP_SH;
                  3'b010:  w_op = OP_SW;
                  default: w_legal = 1'b0;
               endcase
            end
            OPC_OPIMM: begin
               w_legal = 1'b1; w_useRd = 1'b1; w_useRs1 = 1'b1; w_imm32 = w_immI;
               case (w_f3)
                  3'b000: w_op = OP_ADDI;
                  3'b010: w_op = OP_SLTI;
                  3'b011: w_op = OP_SLTIU;
                  3'b100: w_op = OP_XORI;
                  3'b110: w_op = OP_ORI;
                  3'b111: w_op = OP_ANDI;
                  3'b001: begin
                     w_op = OP_SLLI; w_legal = (w_f7 == 7'h00);
                  end
                  default: begin
                     w_op    = (w_f7 == 7'h20) ? OP_SRAI : OP_SRLI;
                     w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                  end
               endcase
            end
            OPC_OP: begin
               w_legal = 1'b1; w_useRd = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1;
               case ({w_f7, w_f3})
                  {7'h00, 3'd0}: w_op = OP_ADD;
                  {7'h20, 3'd0}: w_op = OP_SUB;
                  {7'h00, 3'd1}: w_op = OP_SLL;
                  {7'h00, 3'd2}: w_op = OP_SLT;
                  {7'h00, 3'd3}: w_op = OP_SLTU;
                  {7'h00, 3'd4}: w_op = OP_XOR;
                  {7'h00, 3'd5}: w_op = OP_SRL;
                  {7'h20, 3'd5}: w_op = OP_SRA;
                  {7'h00, 3'd6}: w_op = OP_OR;
                  {7'h00, 3'd7}: w_op = OP_AND;
                  default:       w_legal = 1'b0;
               endcase
            end
            OPC_MISCMEM: begin
               w_legal = 1'b1; w_imm32 = w_immI;
               case (w_f3)
                  3'b000:  w_op = OP_FENCE;
                  3'b001:  w_op = OP_FENCE_I;
                  default: w_legal = 1'b0;
               endcase
            end
            OPC_SYSTEM: begin
               w_imm32 = w_immI;
               if (w_f3 == 3'b000) begin
                  if (in_instr[31:7] == 25'h0) begin
                     w_op = OP_ECALL; w_legal = 1'b1;
                  end else if (in_instr[31:7] == 25'h0002000) begin
                     w_op = OP_EBREAK; w_legal = 1'b1;
                  end
               end
`ifdef NYAKUO_ZICSR_EN
               else if (w_f3 != 3'b100) begin
                  // csr address is zero-extended; the I-variants carry uimm in the rs1 slot
                  w_legal = 1'b1; w_useRd = 1'b1; w_useRs1 = 1'b1;
                  w_imm32 = {20'b0, in_instr[31:20]};
                  case (w_f3)
                     3'b001:  w_op = OP_CSRRW;
                     3'b010:  w_op = OP_CSRRS;
                     3'b011:  w_op = OP_CSRRC;
                     3'b101:  w_op = OP_CSRRWI;
                     3'b110:  w_op = OP_CSRRSI;
                     default: w_op = OP_CSRRCI;
                  endcase
               end
`endif
            end
            default: w_legal = 1'b0;
         endcase
      end
   end

   // Illegal words collapse to a canonical ADDI with every field zeroed.
   always_comb begin
      w_dec.op      = w_legal ? w_op : OP_ADDI;
      w_dec.rd      = (w_legal && w_useRd)  ? in_instr[11:7]  : 5'd0;
      w_dec.rs1     = (w_legal && w_useRs1) ? in_instr[19:15] : 5'd0;
      w_dec.rs2     = (w_legal && w_useRs2) ? in_instr[24:20] : 5'd0;
      w_dec.illegal = ~w_legal;
   end

   assign w_imm = w_legal ? XLEN'(signed'(w_imm32)) : '0;

   assign in_ready  = (w_count < CW'(DEPTH));
   assign out_valid = (w_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   nyakuo_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata ({w_dec, w_imm, in_pc}),
      .o_rdata (w_rdata),
      .o_count (w_count)
   );

   assign {w_head, out_imm, out_pc} = w_rdata;
   assign out_op      = w_head.op;
   assign out_rd      = w_head.rd;
   assign out_rs1     = w_head.rs1;
   assign out_rs2     = w_head.rs2;
   assign out_illegal = w_head.illegal;

endmodule
